// File: rtl/parity_check_controller.sv
// Burst parity checker: accepts BURST_LEN words over valid/ready, counts parity failures, and reports a verdict.
// Optional macro PCC_ABORT_ON_ERR_EN ends the burst on the first failing word.
module parity_check_controller #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              odd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              err_seen
);

`ifdef PCC_ABORT_ON_ERR_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             odd_q;
    logic [CNT_W-1:0] word_idx;

    logic             accept_c;
    logic             bad_c;
    logic             end_c;
    logic [CNT_W-1:0] err_next_c;

    // Per-word verdict and the error count as it will be after this edge
    always_comb begin
        accept_c   = in_valid && in_ready;
        bad_c      = ((^{in_data, in_parity}) != odd_q);
        err_next_c = err_count;
        if (accept_c && bad_c && (err_count != CNT_MAX)) begin
            err_next_c = err_count + CNT_W'(1);
        end
        end_c = accept_c && ((word_idx == LAST_IDX) || (ABORT_EN && bad_c));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            odd_q         <= 1'b0;
            word_idx      <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            err_seen      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= RUN;
                        in_ready      <= 1'b1;
                        busy          <= 1'b1;
                        odd_q         <= odd_mode;
                        word_idx      <= '0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        err_seen      <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        word_idx  <= word_idx + CNT_W'(1);
                        err_count <= err_next_c;
                        if (bad_c && !err_seen) begin
                            first_err_idx <= word_idx;
                            err_seen      <= 1'b1;
                        end
                    end
                    // Verdict is ready in the same cycle as the done pulse
                    if (end_c) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (err_next_c == '0);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_check_controller.sv
// Self-checking bench for parity_check_controller: per-cycle model comparison plus directed literal checks.
// Honours PCC_ABORT_ON_ERR_EN to match the build of the design.
module tb_parity_check_controller;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned BURST_LEN = 8;
    localparam int unsigned CNT_W     = 8;
`ifdef PCC_ABORT_ON_ERR_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              odd_mode = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_parity = 1'b0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  first_err_idx;
    logic              err_seen;

    parity_check_controller #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .odd_mode(odd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_parity(in_parity), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .err_seen(err_seen)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [DATA_W-1:0] wd [BURST_LEN];
    logic              wp [BURST_LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a burst is a list of accepted words and the indices that failed
    bit m_active = 1'b0;
    bit m_ending = 1'b0;
    bit m_odd = 1'b0;
    bit m_pass = 1'b0;
    int m_words = 0;
    int m_bad_idx[$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_active = 1'b0;
            m_ending = 1'b0;
            m_words  = 0;
            m_pass   = 1'b0;
            m_bad_idx.delete();
        end else if (m_ending) begin
            m_ending = 1'b0;
            m_active = 1'b0;
        end else if (m_active) begin
            if (in_valid) begin
                bit bad;
                int ones;
                ones = in_parity ? 1 : 0;
                for (int b = 0; b < int'(DATA_W); b++) ones += in_data[b] ? 1 : 0;
                bad = ((ones % 2) == 1) != m_odd;
                if (bad) m_bad_idx.push_back(m_words);
                m_words++;
                if (m_words == int'(BURST_LEN) || (ABORT && bad)) begin
                    m_ending = 1'b1;
                    m_pass   = (m_bad_idx.size() == 0);
                end
            end
        end else if (start) begin
            m_active = 1'b1;
            m_odd    = odd_mode;
            m_words  = 0;
            m_pass   = 1'b0;
            m_bad_idx.delete();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            sz = m_bad_idx.size();
            check("in_ready", 32'(in_ready), 32'(m_active && !m_ending));
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_ending));
            check("pass", 32'(pass), 32'(m_pass));
            check("err_count", 32'(err_count), 32'((sz > 255) ? 255 : sz));
            check("first_err_idx", 32'(first_err_idx), 32'((sz > 0) ? m_bad_idx[0] : 0));
            check("err_seen", 32'(err_seen), 32'(sz > 0));
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_pass"}, 32'(pass), 32'(0));
        check({tag, "_err_count"}, 32'(err_count), 32'(0));
        check({tag, "_first_err_idx"}, 32'(first_err_idx), 32'(0));
        check({tag, "_err_seen"}, 32'(err_seen), 32'(0));
    endtask

    // vmode: 0 full rate, 1 toggling valid with stray start/valid pulses, 2 random valid
    task automatic run_burst(input bit odd, input int vmode, input int stop_after, output int lat);
        int idx;
        int guard;
        bit v;
        bit acc;
        bit ended;
        int k;
        lat = -1;
        ended = 1'b0;
        @(negedge clk);
        start = 1'b1;
        odd_mode = odd;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        odd_mode = 1'($urandom_range(0, 1));
        idx = 0;
        guard = 0;
        while (idx < int'(BURST_LEN) && guard < 200) begin
            if (stop_after >= 0 && (idx == stop_after || (guard > 0 && !in_ready))) begin
                reset = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check_reset_vals("mid_reset");
                reset = 1'b0;
                return;
            end
            if (guard > 0 && !in_ready) begin
                ended = 1'b1;
                break;
            end
            case (vmode)
                0: v = 1'b1;
                1: v = (guard % 2) == 0;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid  = v;
            in_data   = v ? wd[idx] : DATA_W'($urandom_range(0, 15));
            in_parity = v ? wp[idx] : 1'($urandom_range(0, 1));
            start     = (vmode == 1 && guard == 3);
            acc = v && in_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!ended && idx < int'(BURST_LEN)) check("burst_timeout", 32'(1), 32'(0));
        guard = 0;
        while (!done && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) check("done_timeout", 32'(1), 32'(0));
        lat = cyc - k;
        if (vmode == 1) begin
            start = 1'b1;
            in_valid = 1'b1;
            in_data = 4'b1101;
            in_parity = 1'b0;
        end
    endtask

    task automatic finish_burst(input int vmode);
        @(negedge clk);
        start = 1'b0;
        if (vmode == 1) begin
            @(negedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int e_pass, input int e_err,
                                input int e_first, input int e_seen);
        check({tag, "_pass"}, 32'(pass), 32'(e_pass));
        check({tag, "_err_count"}, 32'(err_count), 32'(e_err));
        check({tag, "_first_err_idx"}, 32'(first_err_idx), 32'(e_first));
        check({tag, "_err_seen"}, 32'(err_seen), 32'(e_seen));
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check_reset_vals("por");

        // All good words, even parity, full rate
        for (int i = 0; i < int'(BURST_LEN); i++) begin wd[i] = 4'b0101; wp[i] = 1'b0; end
        run_burst(1'b0, 0, -1, lat);
        check("t1_done_latency", 32'(lat), 32'(8));
        check_result("t1", 1, 0, 0, 0);
        finish_burst(0);

        // Failures at idx 2 and 5
        wd[2] = 4'b1101; wd[5] = 4'b1101;
        run_burst(1'b0, 0, -1, lat);
        if (ABORT) check_result("t2", 0, 1, 2, 1);
        else check_result("t2", 0, 2, 2, 1);
        finish_burst(0);

        // Alternating words that are good under odd parity
        for (int i = 0; i < int'(BURST_LEN); i++) begin
            wd[i] = (i % 2 == 0) ? 4'b0101 : 4'b1101;
            wp[i] = (i % 2 == 0);
        end
        run_burst(1'b1, 0, -1, lat);
        check_result("t3_odd", 1, 0, 0, 0);
        finish_burst(0);
        run_burst(1'b0, 0, -1, lat);
        if (ABORT) check_result("t3_even", 0, 1, 0, 1);
        else check_result("t3_even", 0, 8, 0, 1);
        finish_burst(0);

        // Toggling valid, stray start in RUN and DONE, stray valid after the burst
        for (int i = 0; i < int'(BURST_LEN); i++) begin wd[i] = 4'b0101; wp[i] = 1'b0; end
        wd[2] = 4'b1101; wd[5] = 4'b1101;
        run_burst(1'b0, 1, -1, lat);
        if (ABORT) check_result("t4", 0, 1, 2, 1);
        else check_result("t4", 0, 2, 2, 1);
        finish_burst(1);
        if (ABORT) check_result("t4_hold", 0, 1, 2, 1);
        else check_result("t4_hold", 0, 2, 2, 1);

        // Reset after three accepted words, one of them failing
        run_burst(1'b0, 0, 3, lat);
        for (int i = 0; i < int'(BURST_LEN); i++) begin wd[i] = 4'b0101; wp[i] = 1'b0; end
        run_burst(1'b0, 0, -1, lat);
        check_result("t5_clean", 1, 0, 0, 0);
        finish_burst(0);

        // Single failure at idx 3
        wd[3] = 4'b1101;
        run_burst(1'b0, 0, -1, lat);
        check("t6_done_latency", 32'(lat), 32'(ABORT ? 4 : 8));
        check_result("t6", 0, 1, 3, 1);
        finish_burst(0);

        // Random bursts
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < int'(BURST_LEN); i++) begin
                wd[i] = DATA_W'($urandom_range(0, 15));
                wp[i] = 1'($urandom_range(0, 1));
            end
            run_burst(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 0 : 2, -1, lat);
            finish_burst(0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/parity_check_controller.md
# parity_check_controller

Sequences a burst of parity-protected 4-bit words through a per-word parity check, accepting one word per cycle over a valid/ready handshake. It counts failing words, records the index of the first failure, and reports a pass/fail verdict when the burst ends. It sits between a nibble source (e.g. a serial deframer) and the status/host logic that consumes the verdict.

## Interface
- `DATA_W`, 4: data word width in bits.
- `BURST_LEN`, 8: words per burst, 1..255.
- `CNT_W`, 8: width of word index and error counter; must satisfy 2^CNT_W > BURST_LEN.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `odd_mode`  in  1  0 = even parity, 1 = odd parity; latched on accepted `start`.
- `in_valid`  in  1  source has a word on `in_data`/`in_parity`.
- `in_ready`  out  1  controller accepts a word this cycle.
- `in_data`  in  DATA_W  data word.
- `in_parity`  in  1  transmitted parity bit.
- `busy`  out  1  burst in progress (RUN or DONE).
- `done`  out  1  one-cycle pulse at burst end.
- `pass`  out  1  last burst had zero errors; valid from `done` until next accepted `start`.
- `err_count`  out  CNT_W  failing words in last/current burst, saturating at 2^CNT_W-1.
- `first_err_idx`  out  CNT_W  index (0-based) of first failing word; 0 if none.
- `err_seen`  out  1  at least one failure in current/last burst.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=0, `busy`=0. `start`=1 -> RUN; latch `odd_mode`; clear `err_count`, `err_seen`, `first_err_idx`, word index, `pass`.
- RUN: `in_ready`=1, `busy`=1. Word accepted when `in_valid && in_ready`. Word is bad when `^{in_data,in_parity}` != latched `odd_mode`. On bad word: `err_count`+1 (saturating); if `err_seen`=0, `first_err_idx` <= current index and `err_seen` <= 1. Index increments per accepted word.
- Acceptance of word index BURST_LEN-1 -> DONE.
- DONE: `in_ready`=0, `done`=1, `pass` <= (final error count == 0); unconditionally -> IDLE next cycle.
- `start` in RUN or DONE ignored. `in_valid` in IDLE/DONE ignored, nothing consumed.
- `in_valid` low in RUN: idle cycle, no state change, no timeout.
- Results (`pass`, `err_count`, `first_err_idx`, `err_seen`) hold in IDLE until next accepted `start`.

## Timing
- Reset values: state IDLE, `in_ready`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=0, `err_seen`=0.
- `reset` has priority over every input; asserting it mid-burst discards the burst, all outputs return to reset values next edge.
- `start` at edge N -> `busy`=1, `in_ready`=1 from cycle N+1.
- Full-rate burst: last word accepted at edge M -> `done`=1 during cycle M+1 -> IDLE at M+2; a new `start` is accepted at M+2 or later.
- `err_count`/`first_err_idx` update on the edge that accepts the word (registered, one cycle after presentation).
- `in_ready` is a pure function of state (no combinational path from `in_valid`).

## Configuration
- `PCC_ABORT_ON_ERR_EN` defined: first bad word accepted in RUN -> DONE next cycle, regardless of remaining count; `pass`=0, `err_count`=1, `first_err_idx` = failing index.
- Undefined: full BURST_LEN words always consumed; errors only counted.

## Test plan
- Even mode, BURST_LEN=8, all words `4'b0101` parity 0 at full rate -> `done` pulse 9 cycles after `start` edge, `pass`=1, `err_count`=0, `err_seen`=0.
- Even mode, words 0..7 = `0101`/p0 except idx 2 and 5 = `1101`/p0 -> `err_count`=2, `first_err_idx`=2, `pass`=0.
- Odd mode, `0101`/p1 and `1101`/p0 alternating -> all pass; same stimulus in even mode -> `err_count`=8, `first_err_idx`=0.
- `in_valid` toggling 1-0-1-0, plus `start` and extra `in_valid` pulses in DONE/IDLE -> exactly 8 words consumed, second `start` ignored while `busy`.
- `reset` asserted after 3 accepted words including one error -> next cycle all outputs at reset values; following burst reports from clean state.
- With `PCC_ABORT_ON_ERR_EN`: bad word at idx 3 -> `done` the cycle after its acceptance, `err_count`=1, `first_err_idx`=3, `in_ready`=0 for remaining words.
